// File: rtl/xkeypad_queue_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : xkeypad_queue_pkg                                            |
// | Brief  : Shared types, register offsets and helpers for the keypad    |
// |          event queue peripheral.                                      |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package xkeypad_queue_pkg;

  localparam int DATA_W      = 32;  // picoVersat data bus width
  localparam int KEYQ_ADDR_W = 2;   // register offset width
  localparam int IDX_W       = 4;   // button index width in a queued event
  localparam int MAX_BTN     = 16;  // widest button vector supported

  // Register offsets within the block
  typedef enum logic [KEYQ_ADDR_W-1:0] {
    REG_STATUS = 2'd0,
    REG_DATA   = 2'd1,
    REG_LEVEL  = 2'd2,
    REG_RSVD   = 2'd3
  } keyq_reg_e;

  // Index of the lowest set bit; 0 when nothing is set (caller qualifies with |v)
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_BTN-1:0] v);
    lowest_set = '0;
    for (int i = MAX_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/xkeypad_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : xkeypad_queue_if                                             |
// | Brief  : Data-bus slave port of the keypad queue (select, write       |
// |          enable, offset, write data, combinational read data).        |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface xkeypad_queue_if;
  import xkeypad_queue_pkg::*;

  logic                   sel;
  logic                   we;
  logic [KEYQ_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]      data_in;
  logic [DATA_W-1:0]      data_out;

  modport master (output sel, output we, output addr, output data_in, input data_out);
  modport slave  (input sel, input we, input addr, input data_in, output data_out);
endinterface
`default_nettype wire

// File: rtl/xkeypad_queue_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : xkey_debounce                                                |
// | Brief  : One button: 2-FF synchroniser, stability counter, debounced  |
// |          level and a single-cycle press pulse on a 0->1 flip.         |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module xkey_debounce #(
  parameter int DEB_CNT = 1000000,
  parameter int DEB_W   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             w_mismatch;
  logic             w_expire;

  assign w_mismatch = sync2_q ^ level_q;
  // Mismatch has been stable for DEB_CNT cycles including this one
  assign w_expire   = w_mismatch && (cnt_q == DEB_W'(DEB_CNT - 1));

  // Next-state: count while the synced input disagrees, flip when it has held long enough
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (w_expire) begin
      level_d = sync2_q;
    end else if (w_mismatch) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  // Pulse coincides with the edge at which the level rises
  assign press_o = w_expire & sync2_q;

endmodule
`default_nettype wire

// File: rtl/xkeypad_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : xkeypad_queue                                                |
// | Brief  : Debounced push-button peripheral; each press queues its      |
// |          button index in a small FIFO read through STATUS/DATA/LEVEL. |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module xkeypad_queue
  import xkeypad_queue_pkg::*;
#(
  parameter int N_BTN   = 4,
  parameter int DEB_CNT = 1000000,
  parameter int DEB_W   = 20,
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  xkeypad_queue_if.slave   bus,
  input  logic [N_BTN-1:0] btn_in
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [N_BTN-1:0]   w_level, w_press;
  logic [IDX_W-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [N_BTN-1:0]   pending_q, pending_d;

  keyq_reg_e          w_reg;
  logic               w_empty, w_full, w_clear, w_pop, w_push, w_push_req, w_drop;
  logic [IDX_W-1:0]   w_push_idx;
  logic [N_BTN-1:0]   w_clr_mask;
  logic               w_unused_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      xkey_debounce #(
        .DEB_CNT (DEB_CNT),
        .DEB_W   (DEB_W)
      ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_in[gi]),
        .level_o (w_level[gi]),
        .press_o (w_press[gi])
      );
    end
  endgenerate

  assign w_reg      = keyq_reg_e'(bus.addr);
  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign w_clear    = bus.sel & bus.we & (w_reg == REG_STATUS);
  assign w_pop      = bus.sel & ~bus.we & (w_reg == REG_DATA) & ~w_empty;
  // One pending button drains per cycle, lowest index first
  assign w_push_req = |pending_q;
  assign w_push_idx = lowest_set(MAX_BTN'(pending_q));
  assign w_clr_mask = w_push_req ? (N_BTN'(1) << w_push_idx) : '0;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  // Write data only matters as a strobe for the STATUS clear
  assign w_unused_data = ^bus.data_in;

  // Next-state for pointers, count, sticky overflow and pending presses; clear dominates
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pending_d  = (pending_q & ~w_clr_mask) | w_press;
    if (w_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      pending_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (w_pop && !w_push) count_d = count_q - 1'b1;
      if (w_drop) overflow_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
    end
  end

  // Event storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push && !w_clear && !rst) mem_q[wr_ptr_q] <= w_push_idx;
  end

  // Read mux, combinational on select, offset and current state
  always_comb begin
    bus.data_out = '0;
    if (bus.sel) begin
      case (w_reg)
        REG_STATUS: begin
          bus.data_out[0]             = w_empty;
          bus.data_out[1]             = w_full;
          bus.data_out[2]             = overflow_q;
          bus.data_out[FIFO_AW+3:3]   = count_q;
        end
        REG_DATA: begin
          if (!w_empty) bus.data_out[IDX_W-1:0] = mem_q[rd_ptr_q];
        end
        REG_LEVEL: begin
          bus.data_out[N_BTN-1:0] = w_level;
        end
        default: bus.data_out = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xkeypad_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_xkeypad_queue                                             |
// | Brief  : Self-checking bench for xkeypad_queue with a short debounce  |
// |          window and a 4-deep FIFO; queued events tracked in a queue.  |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_xkeypad_queue;
  import xkeypad_queue_pkg::*;

  localparam int N_BTN   = 4;
  localparam int DEB_CNT = 4;
  localparam int DEB_W   = 3;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  xkeypad_queue_if  bus ();

  int n_cmp = 0;
  int n_mis = 0;
  int sb[$];           // expected event indices in FIFO order
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] exp_v;

  xkeypad_queue #(
    .N_BTN   (N_BTN),
    .DEB_CNT (DEB_CNT),
    .DEB_W   (DEB_W),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .btn_in (btn_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got running, want finished");
    $fatal(1);
  end

  // Advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle read; a DATA read pops at the edge it spans
  task automatic read_reg(input logic [KEYQ_ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.data_out;
    tick();
    bus.sel = 1'b0;
  endtask

  task automatic write_reg(input logic [KEYQ_ADDR_W-1:0] a);
    bus.sel     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = 32'hDEAD_BEEF;
    tick();
    bus.sel     = 1'b0;
    bus.we      = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic press_release(input int b);
    btn_in[b] = 1'b1;
    repeat (8) tick();
    btn_in[b] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = '0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL reset_status got %h want %h", rd, 32'h1); end
    read_reg(REG_DATA, rd);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL reset_data_empty got %h want %h", rd, 32'h0); end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL reset_status_after_pop got %h want %h", rd, 32'h1); end
    read_reg(REG_LEVEL, rd);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL reset_level got %h want %h", rd, 32'h0); end
    read_reg(REG_RSVD, rd);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL reserved_read got %h want %h", rd, 32'h0); end
    bus.sel = 1'b0; bus.addr = REG_STATUS;
    #1;
    n_cmp++; if (bus.data_out !== 32'h0) begin n_mis++; $display("FAIL unselected_read got %h want %h", bus.data_out, 32'h0); end
  endtask

  task automatic test_single_press();
    btn_in[2] = 1'b1;
    sb.push_back(2);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = REG_LEVEL;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_v = (k == 6) ? 32'h4 : 32'h0;
      n_cmp++; if (bus.data_out !== exp_v) begin n_mis++; $display("FAIL level_latency cycle %0d got %h want %h", k, bus.data_out, exp_v); end
    end
    bus.sel = 1'b0;
    repeat (4) tick();
    btn_in[2] = 1'b0;
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h08) begin n_mis++; $display("FAIL single_status got %h want %h", rd, 32'h08); end
    read_reg(REG_DATA, rd);
    exp_v = DATA_W'(sb.pop_front());
    n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL single_data got %h want %h", rd, exp_v); end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL single_status_empty got %h want %h", rd, 32'h1); end
    repeat (8) tick();
    read_reg(REG_LEVEL, rd);
    n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL release_level got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_bounce();
    btn_in[1] = 1'b1; tick();
    btn_in[1] = 1'b0; tick();
    btn_in[1] = 1'b1; tick();
    btn_in[1] = 1'b0; tick();
    btn_in[1] = 1'b1;
    sb.push_back(1);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = REG_LEVEL;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_v = (k == 6) ? 32'h2 : 32'h0;
      n_cmp++; if (bus.data_out !== exp_v) begin n_mis++; $display("FAIL bounce_level cycle %0d got %h want %h", k, bus.data_out, exp_v); end
    end
    bus.sel = 1'b0;
    repeat (4) tick();
    btn_in[1] = 1'b0;
    repeat (8) tick();
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h08) begin n_mis++; $display("FAIL bounce_one_event got %h want %h", rd, 32'h08); end
    read_reg(REG_DATA, rd);
    exp_v = DATA_W'(sb.pop_front());
    n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL bounce_data got %h want %h", rd, exp_v); end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL bounce_status_empty got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_simultaneous();
    btn_in[3] = 1'b1;
    btn_in[0] = 1'b1;
    sb.push_back(0);
    sb.push_back(3);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = REG_STATUS;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = (k == 8) ? 32'h10 : (k == 7) ? 32'h08 : 32'h01;
      n_cmp++; if (bus.data_out !== exp_v) begin n_mis++; $display("FAIL simul_push cycle %0d got %h want %h", k, bus.data_out, exp_v); end
    end
    bus.sel = 1'b0;
    btn_in[3] = 1'b0;
    btn_in[0] = 1'b0;
    repeat (8) tick();
    for (int j = 0; j < 2; j++) begin
      read_reg(REG_DATA, rd);
      exp_v = DATA_W'(sb.pop_front());
      n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL simul_data %0d got %h want %h", j, rd, exp_v); end
    end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL simul_status_empty got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_overflow();
    logic ovf_exp;
    ovf_exp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (sb.size() < DEPTH) sb.push_back(i % 4);
      else ovf_exp = 1'b1;
      press_release(i % 4);
    end
    exp_v = {29'd0, ovf_exp, 2'b10} | 32'h20;
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL overflow_status got %h want %h", rd, exp_v); end
    write_reg(REG_DATA);
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL data_write_ignored got %h want %h", rd, exp_v); end
    for (int j = 0; j < DEPTH; j++) begin
      read_reg(REG_DATA, rd);
      exp_v = DATA_W'(sb.pop_front());
      n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL overflow_order %0d got %h want %h", j, rd, exp_v); end
    end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h05) begin n_mis++; $display("FAIL overflow_sticky got %h want %h", rd, 32'h05); end
    write_reg(REG_STATUS);
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL clear_status got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 3; i >= 0; i--) begin
      sb.push_back(i);
      press_release(i);
    end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h22) begin n_mis++; $display("FAIL full_status got %h want %h", rd, 32'h22); end
    btn_in[2] = 1'b1;
    repeat (6) tick();
    // The press lands in the FIFO at the same edge this read pops the head
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = REG_DATA;
    #1;
    exp_v = DATA_W'(sb.pop_front());
    sb.push_back(2);
    n_cmp++; if (bus.data_out !== exp_v) begin n_mis++; $display("FAIL pushpop_head got %h want %h", bus.data_out, exp_v); end
    tick();
    bus.sel = 1'b0;
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h22) begin n_mis++; $display("FAIL pushpop_status got %h want %h", rd, 32'h22); end
    btn_in[2] = 1'b0;
    repeat (8) tick();
    for (int j = 0; j < DEPTH; j++) begin
      read_reg(REG_DATA, rd);
      exp_v = DATA_W'(sb.pop_front());
      n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL pushpop_drain %0d got %h want %h", j, rd, exp_v); end
    end
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL pushpop_empty got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_clear_then_reuse();
    press_release(3);
    press_release(0);
    write_reg(REG_STATUS);
    sb.delete();
    read_reg(REG_STATUS, rd);
    n_cmp++; if (rd !== 32'h1) begin n_mis++; $display("FAIL clear_nonempty got %h want %h", rd, 32'h1); end
    sb.push_back(1);
    press_release(1);
    read_reg(REG_DATA, rd);
    exp_v = DATA_W'(sb.pop_front());
    n_cmp++; if (rd !== exp_v) begin n_mis++; $display("FAIL reuse_data got %h want %h", rd, exp_v); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_clear_then_reuse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
